// File: rtl/matmul_pkg.sv
// Shared types and timing constants for the systolic-array sequencer.
// Contents:
//   state_e      sequencer FSM states
//   feed_cycles  number of mac_en cycles for an n x n array
//   run_cycles   go-sampling edge to done pulse, in cycles
//   FEED_CYCLES  / RUN_CYCLES: values for the default array size
package matmul_pkg;

  localparam int unsigned NDefault = 3;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned feed_cycles(input int unsigned n);
    return 3 * n - 2;
  endfunction

  function automatic int unsigned run_cycles(input int unsigned n);
    return 3 * n + 2;
  endfunction

  localparam int unsigned FEED_CYCLES = feed_cycles(NDefault);
  localparam int unsigned RUN_CYCLES  = run_cycles(NDefault);

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Bundle between the sequencer, the operand buffers and the MAC array.
// Signals:
//   go                   start request into the sequencer
//   busy, done           run status
//   rd_en, rd_addr       operand-buffer read (1-cycle latency)
//   a_rd_data, b_rd_data column k of A / row k of B, lane i at [i*DW +: DW]
//   feed_a, feed_b       skewed array edge inputs
//   mac_en, mac_clr      PE accumulate enable / synchronous clear
// Modports: master = sequencer, slave = buffers/array/requester side.
interface matmul_seq_ctrl_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = $clog2(N)
);
  logic          go;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N*DW-1:0] a_rd_data;
  logic [N*DW-1:0] b_rd_data;
  logic [N*DW-1:0] feed_a;
  logic [N*DW-1:0] feed_b;
  logic          mac_en;
  logic          mac_clr;

  modport master (
    input  go, a_rd_data, b_rd_data,
    output busy, done, rd_en, rd_addr, feed_a, feed_b, mac_en, mac_clr
  );

  modport slave (
    output go, a_rd_data, b_rd_data,
    input  busy, done, rd_en, rd_addr, feed_a, feed_b, mac_en, mac_clr
  );
endinterface

// File: rtl/operand_skew.sv
// N-lane triangular delay line feeding one edge of the systolic array.
// Lane i is delayed by i+1 registers so operand k reaches lane i one cycle
// later than lane i-1. Stage 0 loads zero whenever the input is not valid,
// so every lane outputs zero outside its operand window.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   vld_i          data_i carries a valid operand word this cycle
//   data_i         N lanes of DW bits, lane i at [i*DW +: DW]
//   data_o         skewed lanes, same packing
module operand_skew #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            vld_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N*DW-1:0] data_o
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] sr_q [0:i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s <= i; s++) begin
          sr_q[s] <= '0;
        end
      end else begin
        sr_q[0] <= vld_i ? data_i[i*DW +: DW] : '0;
        for (int s = 1; s <= i; s++) begin
          sr_q[s] <= sr_q[s-1];
        end
      end
    end

    assign data_o[i*DW +: DW] = sr_q[i];
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the NxN systolic MAC array.
// On go (sampled in idle) it clears the accumulators, reads word k = 0..N-1
// from both operand buffers, skews the returned words onto the array edges
// and holds mac_en until the last product reaches PE(N-1,N-1), then pulses
// done. cnt_q holds the cycle number of the run (go-sampling edge = 0).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         matmul_seq_ctrl_if.master (go, status, buffer read, feeds, PE control)
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  matmul_seq_ctrl_if.master   bus
);

  localparam int unsigned CntW    = $clog2(3 * N + 3);
  localparam int unsigned FeedCyc = feed_cycles(N);
  localparam int unsigned RunCyc  = run_cycles(N);

  typedef logic [CntW-1:0] cnt_t;

  // Word k is read in cycle 2+k, arrives in 3+k and leaves lane 0 in 4+k.
  localparam cnt_t FirstMac  = cnt_t'(4);
  localparam cnt_t LastMac   = cnt_t'(3 + FeedCyc);
  localparam cnt_t LastFetch = cnt_t'(N + 1);
  localparam cnt_t LastDrain = cnt_t'(RunCyc - 1);

  state_e        state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mac_en_q, mac_en_d;
  logic          rd_vld_q;
  logic          rd_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d = StClear;
          cnt_d   = cnt_t'(1);
        end
      end
      StClear: begin
        state_d = StFetch;
        cnt_d   = cnt_q + cnt_t'(1);
      end
      StFetch: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LastFetch) state_d = StDrain;
      end
      StDrain: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == LastDrain) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the cycle that state is entered.
  always_comb begin
    busy_d    = state_d inside {StClear, StFetch, StDrain};
    done_d    = (state_d == StDone);
    mac_en_d  = busy_d && (cnt_d >= FirstMac) && (cnt_d <= LastMac);
    rd_addr_d = rd_addr_q;
    if (state_d == StFetch) rd_addr_d = AW'(cnt_d - cnt_t'(2));
  end

  assign rd_en = (state_q == StFetch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_en_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mac_en_q  <= mac_en_d;
      rd_vld_q  <= rd_en;  // buffer read latency is one cycle
    end
  end

  operand_skew #(
    .N  (N),
    .DW (DW)
  ) u_skew_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (rd_vld_q),
    .data_i (bus.a_rd_data),
    .data_o (bus.feed_a)
  );

  operand_skew #(
    .N  (N),
    .DW (DW)
  ) u_skew_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .vld_i  (rd_vld_q),
    .data_i (bus.b_rd_data),
    .data_o (bus.feed_b)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.mac_en  = mac_en_q;
  assign bus.mac_clr = (state_q == StClear);
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl (N=3, DW=8) with a 1-cycle operand
// buffer model and a behavioural 3x3 systolic PE array sampling on negedge.
module tb_matmul_seq_ctrl;

  localparam int TrLen = 1024;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   t0 = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  matmul_seq_ctrl_if #(.N(3), .DW(8)) bus ();

  matmul_seq_ctrl #(.N(3), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand matrices, row-major [row][col].
  logic [7:0] a_m [3][3];
  logic [7:0] b_m [3][3];

  // Buffer model: word k = column k of A / row k of B; junk when not read.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (bus.rd_en) begin
        bus.a_rd_data[i*8 +: 8] <= a_m[i][bus.rd_addr];
        bus.b_rd_data[i*8 +: 8] <= b_m[bus.rd_addr][i];
      end else begin
        bus.a_rd_data[i*8 +: 8] <= 8'hEE;
        bus.b_rd_data[i*8 +: 8] <= 8'hEE;
      end
    end
  end

  // PE array model: a moves right, b moves down, one hop per cycle.
  logic [7:0] acc [3][3];
  logic [7:0] ap  [3][3];
  logic [7:0] bp  [3][3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        logic [7:0] a_in;
        logic [7:0] b_in;
        if (j == 0) a_in = bus.feed_a[i*8 +: 8];
        else        a_in = ap[i][j-1];
        if (i == 0) b_in = bus.feed_b[j*8 +: 8];
        else        b_in = bp[i-1][j];
        ap[i][j] <= a_in;
        bp[i][j] <= b_in;
        if (bus.mac_clr)     acc[i][j] <= 8'd0;
        else if (bus.mac_en) acc[i][j] <= acc[i][j] + a_in * b_in;
      end
    end
  end

  // Per-cycle trace, indexed by absolute cycle.
  logic        tr_me [TrLen];
  logic        tr_dn [TrLen];
  logic        tr_rd [TrLen];
  logic        tr_bs [TrLen];
  logic        tr_cl [TrLen];
  logic [1:0]  tr_ra [TrLen];
  logic [23:0] tr_fa [TrLen];
  logic [23:0] tr_fb [TrLen];

  always @(negedge clk) begin
    if (cyc < TrLen) begin
      tr_me[cyc] <= bus.mac_en;
      tr_dn[cyc] <= bus.done;
      tr_rd[cyc] <= bus.rd_en;
      tr_bs[cyc] <= bus.busy;
      tr_cl[cyc] <= bus.mac_clr;
      tr_ra[cyc] <= bus.rd_addr;
      tr_fa[cyc] <= bus.feed_a;
      tr_fb[cyc] <= bus.feed_b;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bit c of the result = selected signal at cycle base+c.
  // sel: 0 mac_en, 1 done, 2 rd_en, 3 busy, 4 mac_clr,
  //      10+i feed_a lane i nonzero, 20+j feed_b lane j nonzero.
  function automatic logic [15:0] mask_of(input int sel, input int base);
    logic [15:0] m;
    m = '0;
    for (int c = 0; c < 16; c++) begin
      int   ix;
      logic b;
      ix = base + c;
      case (sel)
        0: b = tr_me[ix];
        1: b = tr_dn[ix];
        2: b = tr_rd[ix];
        3: b = tr_bs[ix];
        4: b = tr_cl[ix];
        default: begin
          if (sel >= 20) b = (tr_fb[ix][(sel-20)*8 +: 8] != 8'd0);
          else           b = (tr_fa[ix][(sel-10)*8 +: 8] != 8'd0);
        end
      endcase
      m[c] = b;
    end
    return m;
  endfunction

  function automatic logic [63:0] outs_vec();
    return {9'd0, bus.busy, bus.done, bus.rd_en, bus.mac_en, bus.mac_clr,
            bus.rd_addr, bus.feed_a, bus.feed_b};
  endfunction

  // Element (r,c) sits at the (3r+c)-th byte from the top.
  task automatic load(input logic [71:0] a, input logic [71:0] b);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a_m[r][c] = a[71 - 8*(3*r + c) -: 8];
        b_m[r][c] = b[71 - 8*(3*r + c) -: 8];
      end
    end
  endtask

  task automatic check_c(input string tag, input logic [71:0] exp);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        check_eq($sformatf("%s_c%0d%0d", tag, r, c), 64'(acc[r][c]),
                 64'(exp[71 - 8*(3*r + c) -: 8]));
      end
    end
  endtask

  task automatic goto(input int rel);
    while (cyc < t0 + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse();
    t0 = cyc;
    bus.go = 1'b1;
    goto(1);
    bus.go = 1'b0;
  endtask

  localparam logic [71:0] MatI   = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [71:0] MatB   = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [71:0] Mat2I  = 72'h02_00_00_00_02_00_00_00_02;
  localparam logic [71:0] Mat2B  = 72'h02_04_06_08_0A_0C_0E_10_12;
  localparam logic [71:0] Ones   = 72'h01_01_01_01_01_01_01_01_01;
  localparam logic [71:0] Threes = 72'h03_03_03_03_03_03_03_03_03;
  localparam logic [71:0] Sixt   = 72'h10_10_10_10_10_10_10_10_10;
  localparam logic [71:0] MatA5  = 72'h01_02_00_00_01_00_02_00_01;
  localparam logic [71:0] MatB5  = 72'h01_00_01_00_02_00_01_01_01;
  localparam logic [71:0] MatC5  = 72'h01_04_01_00_02_00_03_01_03;

  initial begin
    rst_n  = 1'b0;
    bus.go = 1'b0;
    load(72'd0, 72'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outs", outs_vec(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: identity A
    load(MatI, MatB);
    start_pulse();
    goto(16);
    check_eq("t1_mac_en", 64'(mask_of(0, t0)), 64'h07F0);
    check_eq("t1_done",   64'(mask_of(1, t0)), 64'h0800);
    check_eq("t1_rd_en",  64'(mask_of(2, t0)), 64'h001C);
    check_eq("t1_busy",   64'(mask_of(3, t0)), 64'h07FE);
    check_eq("t1_clr",    64'(mask_of(4, t0)), 64'h0002);
    check_eq("t1_rd_addr", 64'({tr_ra[t0+2], tr_ra[t0+3], tr_ra[t0+4], tr_ra[t0+6]}), 64'h1A);
    check_eq("t1_fa_c6", 64'(tr_fa[t0+6]), 64'h000100);
    check_eq("t1_fb_c6", 64'(tr_fb[t0+6]), 64'h030507);
    check_eq("t1_fb_c8", 64'(tr_fb[t0+8]), 64'h090000);
    check_c("t1", MatB);

    // 2: all ones, lane windows
    load(Ones, Ones);
    start_pulse();
    goto(16);
    check_eq("t2_fa0", 64'(mask_of(10, t0)), 64'h0070);
    check_eq("t2_fa1", 64'(mask_of(11, t0)), 64'h00E0);
    check_eq("t2_fa2", 64'(mask_of(12, t0)), 64'h01C0);
    check_eq("t2_fb2", 64'(mask_of(22, t0)), 64'h01C0);
    check_c("t2", Threes);

    // 3: go pulses while busy are ignored
    load(MatI, MatB);
    start_pulse();
    goto(5);  bus.go = 1'b1;
    goto(6);  bus.go = 1'b0;
    goto(9);  bus.go = 1'b1;
    goto(10); bus.go = 1'b0;
    goto(16);
    check_eq("t3_rd_en", 64'(mask_of(2, t0)), 64'h001C);
    check_eq("t3_done",  64'(mask_of(1, t0)), 64'h0800);
    check_eq("t3_clr",   64'(mask_of(4, t0)), 64'h0002);
    check_eq("t3_busy",  64'(mask_of(3, t0)), 64'h07FE);
    check_c("t3", MatB);

    // 4: reset mid-fetch, then a clean rerun
    load(Mat2I, MatB);
    start_pulse();
    goto(3);
    check_eq("t4_pre_rst_rd_en", 64'(bus.rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_outs", outs_vec(), 64'd0);
    goto(5);
    rst_n = 1'b1;
    goto(6);
    start_pulse();
    goto(16);
    check_eq("t4_clr",    64'(mask_of(4, t0)), 64'h0002);
    check_eq("t4_rd_en",  64'(mask_of(2, t0)), 64'h001C);
    check_eq("t4_mac_en", 64'(mask_of(0, t0)), 64'h07F0);
    check_eq("t4_done",   64'(mask_of(1, t0)), 64'h0800);
    check_c("t4", Mat2B);

    // 5: go held high, back-to-back runs with new operands
    load(Ones, Ones);
    t0 = cyc;
    bus.go = 1'b1;
    goto(8);
    load(MatA5, MatB5);
    goto(12);
    check_c("t5_run1", Threes);
    goto(20);
    bus.go = 1'b0;
    goto(28);
    check_eq("t5_clr",       64'(mask_of(4, t0)), 64'h2002);
    check_eq("t5_done1",     64'(mask_of(1, t0)), 64'h0800);
    check_eq("t5_r2_mac_en", 64'(mask_of(0, t0 + 12)), 64'h07F0);
    check_eq("t5_r2_rd_en",  64'(mask_of(2, t0 + 12)), 64'h001C);
    check_eq("t5_r2_done",   64'(mask_of(1, t0 + 12)), 64'h0800);
    check_c("t5_run2", MatC5);

    // 6: products wrap in the array, controller timing unchanged
    load(Sixt, Sixt);
    start_pulse();
    goto(16);
    check_eq("t6_mac_en", 64'(mask_of(0, t0)), 64'h07F0);
    check_eq("t6_done",   64'(mask_of(1, t0)), 64'h0800);
    check_c("t6", 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
